// File: rtl/xor_parity_accum.sv
// xor_parity_accum: XOR/parity engine over a word stream.
//
// The block computes two kinds of XOR result:
//   - Per word: a combinational prefix XOR across the word, where prefix[i] = ^in_data[i:0].
//   - Per frame: a column-wise XOR of FRAME_LEN accepted words. The result is presented with
//     a valid/ready handshake.
//
// Optional feature (macro PARITY_CHECK_EN):
//   - Adds the ports in_exp_par and out_err.
//   - The block compares the frame parity against in_exp_par, sampled on the last-word accept.
//
// Ports:
//   clk         in   1      clock; all state updates on the rising edge
//   rst         in   1      synchronous active-high reset
//   in_valid    in   1      source word valid
//   in_ready    out  1      block can accept a word
//   in_data     in   WIDTH  source word
//   prefix      out  WIDTH  combinational prefix XOR of in_data
//   word_cnt    out  CW     words accepted in the current frame
//   out_valid   out  1      frame result valid
//   out_ready   in   1      sink accepts the result
//   out_word    out  WIDTH  XOR of all words of the frame
//   out_parity  out  1      reduction XOR of out_word
//   in_exp_par  in   1      expected frame parity        (PARITY_CHECK_EN only)
//   out_err     out  1      frame parity != in_exp_par   (PARITY_CHECK_EN only)

module xor_parity_accum #(
   parameter  int unsigned WIDTH     = 4,
   parameter  int unsigned FRAME_LEN = 8,
   localparam int unsigned CW        = $clog2(FRAME_LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] prefix,
   output logic [CW-1:0]    word_cnt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_word,
   output logic             out_parity
`ifdef PARITY_CHECK_EN
  ,input  logic             in_exp_par,
   output logic             out_err
`endif
);

   typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_word_q, out_word_d;
   logic             out_parity_q, out_parity_d;
`ifdef PARITY_CHECK_EN
   logic             out_err_q, out_err_d;
`endif

   logic             acc_in, acc_out, last_word;
   logic [WIDTH-1:0] acc_next;

   // Each prefix bit is an independent reduction; no ripple between bits.
   for (genvar i = 0; i < WIDTH; i++) begin : g_prefix
      assign prefix[i] = ^in_data[i:0];
   end

   // A result still waiting for the sink stalls the input.
   // in_ready does not depend on in_valid.
   assign in_ready  = !out_valid_q || out_ready;
   assign acc_in    = in_valid && in_ready;
   assign acc_out   = out_valid_q && out_ready;
   assign acc_next  = acc_q ^ in_data;
   assign last_word = (cnt_q == CW'(FRAME_LEN - 1));

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      out_valid_d  = out_valid_q;
      out_word_d   = out_word_q;
      out_parity_d = out_parity_q;
`ifdef PARITY_CHECK_EN
      out_err_d    = out_err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (acc_in) begin
               acc_d   = in_data;
               cnt_d   = CW'(1);
               state_d = StAccum;
            end
         end
         StAccum: begin
            if (acc_in) begin
               if (last_word) begin
                  out_word_d   = acc_next;
                  out_parity_d = ^acc_next;
`ifdef PARITY_CHECK_EN
                  out_err_d    = (^acc_next) != in_exp_par;
`endif
                  out_valid_d  = 1'b1;
                  acc_d        = '0;
                  cnt_d        = '0;
                  state_d      = StHold;
               end else begin
                  acc_d = acc_next;
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         StHold: begin
            if (acc_out) begin
               out_valid_d = 1'b0;
               if (acc_in) begin
                  // First word of the next frame is taken in the same cycle the result drains.
                  acc_d   = in_data;
                  cnt_d   = CW'(1);
                  state_d = StAccum;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         acc_q        <= '0;
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         out_word_q   <= '0;
         out_parity_q <= 1'b0;
`ifdef PARITY_CHECK_EN
         out_err_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         out_word_q   <= out_word_d;
         out_parity_q <= out_parity_d;
`ifdef PARITY_CHECK_EN
         out_err_q    <= out_err_d;
`endif
      end
   end

   assign word_cnt   = cnt_q;
   assign out_valid  = out_valid_q;
   assign out_word   = out_word_q;
   assign out_parity = out_parity_q;
`ifdef PARITY_CHECK_EN
   assign out_err    = out_err_q;
`endif

endmodule
